egress_link_port: RTL
=====================

// Module: egress_link_port
// PURPOSE
//  Output stage fed directly by the 7-input priority/reduction mux of one switch direction.
//  - Buffers the mux output flits and forwards them onto the inter-node link.
//  - Uses credit-based flow control against the downstream node's input FIFO.
//  - Raises almost_full early so the switch can throttle its inputs.
//    The mux has no stall input, so backpressure has to be applied ahead of it.
// PARAMETERS
//  DataWidth         256  flit width; bit DataWidth-1 is the valid bit
//  FIFODepth         8    egress buffer depth in flits; power of 2, >=4
//  Credits           4    downstream buffer slots = initial and maximum credit count
//  CreditWidth       4    credit counter width; must hold Credits
//  AlmostFullMargin  3    almost_full asserts when occupancy >= FIFODepth-AlmostFullMargin
// PORTS
//  clk          in   1                      single clock, rising edge
//  rst          in   1                      asynchronous, active-low reset
//  in           in   DataWidth              flit from mux out; valid when in[DataWidth-1]=1
//  credit_in    in   1                      1-cycle pulse: downstream freed one slot
//  out          out  DataWidth              registered link flit; all-zero when idle
//  almost_full  out  1                      registered occupancy warning to switch inputs
//  occupancy    out  $clog2(FIFODepth)+1    current buffered flit count
//  overflow     out  1                      sticky: a valid flit arrived while the FIFO was full
//  credit_err   out  1                      sticky: credit_in arrived while credits==Credits
// BEHAVIOUR
//  Reset (rst=0, async)
//   - out=0, almost_full=0, occupancy=0, overflow=0, credit_err=0
//   - credits=Credits; FIFO pointers=0
//  Enqueue
//   - Each edge with in[DataWidth-1]=1: flit written at the tail if not full.
//   - Full on arrival: flit dropped, overflow<=1 (sticky until reset).
//  Dequeue (combinational decision, registered result)
//   - send = ~empty && credits!=0.
//   - On send: out<=head, head popped, credits decrement.
//   - Otherwise out<=0. out never repeats a flit.
//  Latency
//   - Flit sampled at edge k, FIFO empty, credits>0: appears on out after edge k+1.
//   - No same-cycle bypass.
//  Simultaneous enqueue and dequeue
//   - When full: the pop frees the slot first, so the incoming flit is accepted.
//   - occupancy is unchanged.
//  Credits
//   - credit_in only: credits+1.
//   - send only: credits-1.
//   - Both in the same cycle: credits unchanged.
//   - credit_in at credits==Credits with no send: ignored (saturate), credit_err<=1.
//   - credits never underflow, because send requires credits!=0.
//  almost_full
//   - Registered from post-update occupancy >= FIFODepth-AlmostFullMargin.
//  Pointers
//   - Wrap modulo FIFODepth.
//   - full = occupancy==FIFODepth; empty = occupancy==0.
//  Reset mid-operation
//   - Buffered flits are discarded and credits restored immediately.
//   - out goes to 0 asynchronously.
//  Flit contents
//   - No field is modified: priority, exit, index, weight and payload pass through untouched.
// CONFIGURATION
//  EGRESS_STATS_EN defined
//   - Adds outputs sent_count[31:0] and credit_stall_count[31:0], both reset to 0.
//   - sent_count increments on each send.
//   - credit_stall_count increments each cycle with ~empty && credits==0.
//   - Both wrap at 2^32.
//  EGRESS_STATS_EN undefined
//   - Neither port nor the counter logic exists.
//   - All other behaviour is identical.
// TESTING
//  T1: reset, inject 1 flit (MSB=1, payload 0xA5), credit_in idle
//      -> out=flit after edge k+1, credits 4->3, occupancy 1->0.
//  T2: 6 flits back-to-back, no credit_in
//      -> first 4 sent on consecutive cycles, credits reach 0;
//         2 remain, occupancy=2, out=0 afterward.
//      Then pulse credit_in twice -> remaining 2 sent, in order.
//  T3: credits=0, inject 9 flits -> first 8 buffered, 9th dropped, overflow=1;
//      almost_full=1 from occupancy 5 onward.
//  T4: credits=4, FIFO empty, pulse credit_in -> credit_err=1, credits stay 4.
//  T5: send and credit_in in the same cycle at credits=2 -> credits stay 2.
//  T6: assert rst=0 mid-burst with occupancy=5
//      -> out=0 at once, occupancy=0, credits=4;
//         first flit after release has the 1-cycle latency.
//      With EGRESS_STATS_EN: sent_count=0 after reset.

Source files
------------

// File: rtl/egress_link_port_if.sv
// -----------------------------------------------------------------------------
// egress_link_port_if
//
// Purpose:
//   Groups the flit and credit signals between one switch direction and its
//   egress link stage.
//   - master: the switch side. It drives mux flits and downstream credits and
//     observes the link output and the status flags.
//   - slave: the egress_link_port side.
//
// Signals:
//   in                  flit from the priority/reduction mux; in[DataWidth-1] = valid
//   credit_in           one-cycle pulse, downstream freed one buffer slot
//   out                 registered link flit, all-zero when idle
//   almost_full         registered early occupancy warning to the switch inputs
//   occupancy           number of flits currently buffered
//   overflow            sticky, a valid flit was dropped because the FIFO was full
//   credit_err          sticky, a credit arrived while the counter was already full
//   sent_count          (EGRESS_STATS_EN only) flits sent on the link
//   credit_stall_count  (EGRESS_STATS_EN only) cycles stalled for lack of credit
//
// Configuration macro: EGRESS_STATS_EN adds the two statistics counters.
// -----------------------------------------------------------------------------
interface egress_link_port_if #(
    parameter int DataWidth = 256,
    parameter int FIFODepth = 8
);
    localparam int OccWidth = $clog2(FIFODepth) + 1;

    logic [DataWidth-1:0] in;
    logic                 credit_in;
    logic [DataWidth-1:0] out;
    logic                 almost_full;
    logic [OccWidth-1:0]  occupancy;
    logic                 overflow;
    logic                 credit_err;
`ifdef EGRESS_STATS_EN
    logic [31:0]          sent_count;
    logic [31:0]          credit_stall_count;
`endif

    modport master (
        output in,
        output credit_in,
        input  out,
        input  almost_full,
        input  occupancy,
        input  overflow,
        input  credit_err
`ifdef EGRESS_STATS_EN
        ,
        input  sent_count,
        input  credit_stall_count
`endif
    );

    modport slave (
        input  in,
        input  credit_in,
        output out,
        output almost_full,
        output occupancy,
        output overflow,
        output credit_err
`ifdef EGRESS_STATS_EN
        ,
        output sent_count,
        output credit_stall_count
`endif
    );

endinterface

// File: rtl/egress_link_port.sv
// -----------------------------------------------------------------------------
// egress_link_port
//
// Purpose:
//   Output stage for one switch direction. It buffers flits produced by the
//   7-input priority/reduction mux and forwards them onto the inter-node link
//   under credit-based flow control against the downstream input FIFO. The mux
//   cannot be stalled, so almost_full is raised early to let the switch throttle
//   its inputs before this buffer fills.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   egress_link_port_if.slave
//         in/credit_in                         inputs from the switch and the link
//         out/almost_full/occupancy            link flit and buffer status
//         overflow/credit_err                  sticky error flags
//         sent_count/credit_stall_count        statistics (EGRESS_STATS_EN only)
//
// Configuration macro:
//   EGRESS_STATS_EN  when defined, adds the 32-bit sent_count and
//                    credit_stall_count counters. Both wrap.
//
// Flits are never modified. The whole DataWidth word, including the valid bit,
// priority/exit/index/weight fields and payload, is stored and replayed verbatim.
// -----------------------------------------------------------------------------
module egress_link_port #(
    parameter int DataWidth        = 256,
    parameter int FIFODepth        = 8,
    parameter int Credits          = 4,
    parameter int CreditWidth      = 4,
    parameter int AlmostFullMargin = 3
) (
    input  logic              clk,
    input  logic              rst,
    egress_link_port_if.slave bus
);

    localparam int PtrWidth    = $clog2(FIFODepth);
    localparam int OccWidth    = PtrWidth + 1;
    localparam int AfThreshold = FIFODepth - AlmostFullMargin;

    // Buffer storage and its bookkeeping
    logic [DataWidth-1:0]   mem_q [FIFODepth];
    logic [DataWidth-1:0]   mem_d [FIFODepth];
    logic [PtrWidth-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [PtrWidth-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [OccWidth-1:0]    occ_q,     occ_d;

    // Link side state
    logic [CreditWidth-1:0] credits_q, credits_d;
    logic [DataWidth-1:0]   out_q,     out_d;

    // Status flags
    logic                   almost_full_q, almost_full_d;
    logic                   overflow_q,    overflow_d;
    logic                   credit_err_q,  credit_err_d;

    // Per-cycle decisions
    logic                   in_valid;
    logic                   empty;
    logic                   full;
    logic                   send;
    logic                   accept;

`ifdef EGRESS_STATS_EN
    logic [31:0]            sent_count_q,         sent_count_d;
    logic [31:0]            credit_stall_count_q, credit_stall_count_d;
`endif

    // Dequeue/enqueue decision. A pop is decided before the push, so when the
    // buffer is full and a flit is leaving in the same cycle, the slot it frees
    // is what the incoming flit lands in.
    always_comb begin
        in_valid = bus.in[DataWidth-1];
        empty    = (occ_q == '0);
        full     = (occ_q == OccWidth'(FIFODepth));
        send     = !empty && (credits_q != '0);
        accept   = in_valid && (!full || send);
    end

    // Next state for the buffer. The pointers wrap naturally because the depth
    // is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (accept) begin
            mem_d[wr_ptr_q] = bus.in;
            wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
        end

        if (send) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end

        occ_d = occ_q + OccWidth'(accept) - OccWidth'(send);
    end

    // Link output and credit accounting. A credit return and a send in the
    // same cycle cancel out. A credit arriving with the counter already full and
    // nothing being sent cannot be real, so it is dropped and flagged.
    always_comb begin
        out_d        = '0;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;

        if (send) begin
            out_d = mem_q[rd_ptr_q];
        end

        case ({bus.credit_in, send})
            2'b10: begin
                if (credits_q == CreditWidth'(Credits)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CreditWidth'(1);
                end
            end
            2'b01: begin
                credits_d = credits_q - CreditWidth'(1);
            end
            default: begin
                credits_d = credits_q;
            end
        endcase
    end

    // Status flags. almost_full looks at the occupancy after this cycle's
    // push/pop, so the switch sees the warning one cycle earlier than it would
    // if the flag followed the registered count.
    always_comb begin
        almost_full_d = (occ_d >= OccWidth'(AfThreshold));
        overflow_d    = overflow_q || (in_valid && !accept);
    end

`ifdef EGRESS_STATS_EN
    // Statistics counters. A stall cycle is one where data is waiting but the
    // downstream node has no room for it.
    always_comb begin
        sent_count_d         = sent_count_q;
        credit_stall_count_d = credit_stall_count_q;

        if (send) begin
            sent_count_d = sent_count_q + 32'd1;
        end

        if (!empty && (credits_q == '0)) begin
            credit_stall_count_d = credit_stall_count_q + 32'd1;
        end
    end
`endif

    // Flit storage is not reset. The pointers and occupancy alone determine
    // which entries hold live data.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state. The asynchronous reset discards all buffered flits,
    // restores the full credit count and blanks the link immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            credits_q     <= CreditWidth'(Credits);
            out_q         <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            credit_err_q  <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            credits_q     <= credits_d;
            out_q         <= out_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            credit_err_q  <= credit_err_d;
        end
    end

`ifdef EGRESS_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_count_q         <= '0;
            credit_stall_count_q <= '0;
        end else begin
            sent_count_q         <= sent_count_d;
            credit_stall_count_q <= credit_stall_count_d;
        end
    end
`endif

    // Output drive
    always_comb begin
        bus.out         = out_q;
        bus.almost_full = almost_full_q;
        bus.occupancy   = occ_q;
        bus.overflow    = overflow_q;
        bus.credit_err  = credit_err_q;
    end

`ifdef EGRESS_STATS_EN
    always_comb begin
        bus.sent_count         = sent_count_q;
        bus.credit_stall_count = credit_stall_count_q;
    end
`endif

endmodule
